fp32_mul_arbiter: RTL and testbench



---
 rtl/fp32_mul_pkg.sv | 26 ++
 rtl/fp32_mul_arbiter_rr.sv | 49 ++++
 rtl/fp32_mul_arbiter.sv | 124 ++++++++++++
 tb/tb_fp32_mul_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_mul_pkg.sv
//------------------------------------------------------------------------------
// fp32_mul_pkg : shared FP32 types and constants for the multiplier arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package fp32_mul_pkg;

    typedef logic [31:0] fp32_t;

    localparam int    FP32_MUL_LAT = 4;
    localparam fp32_t FP32_ZERO    = 32'h0000_0000;
    localparam fp32_t FP32_INF     = 32'h7F80_0000;

    // Tag id is sized for up to 256 requesters; users compare only the low ID_W bits.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/fp32_mul_arbiter_rr.sv
//------------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter, search starts at the pointer and wraps
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    logic [ID_W-1:0] r_ptr;
    int              w_idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                grant[w_idx] = 1'b1;
                grant_id     = ID_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp32_mul_arbiter.sv
//------------------------------------------------------------------------------
// fp32_mul_arbiter : shares one pipelined FP32 multiplier among N_REQ clients.
// Optional perf counters (stall_cnt, issue_cnt) under FP32_MUL_ARB_PERF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fp32_mul_arbiter
    import fp32_mul_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int MUL_LAT = FP32_MUL_LAT,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_x1,
    input  logic [N_REQ*32-1:0] req_x2,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [31:0]         rsp_y,
    output logic                mul_en,
    output logic [31:0]         mul_x1,
    output logic [31:0]         mul_x2,
    input  logic [31:0]         mul_y
`ifdef FP32_MUL_ARB_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [N_REQ*32-1:0] issue_cnt
`endif
);

    tag_t             r_tag [MUL_LAT];
    tag_t             w_out;
    logic             w_stall;
    logic             w_issue;
    logic             w_any;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gid;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .en       (w_issue),
        .grant    (w_grant),
        .grant_id (w_gid),
        .any      (w_any)
    );

    assign w_out     = r_tag[MUL_LAT-1];
    assign w_stall   = w_out.vld & ~rsp_ready[w_out.id[ID_W-1:0]];
    assign mul_en    = ~w_stall;
    assign w_issue   = w_any & ~w_stall;
    assign req_ready = w_grant & {N_REQ{~w_stall}};
    assign rsp_y     = mul_y;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = w_out.vld && (w_out.id == TAG_ID_W'(i));
        end
    end

    // Idle slots feed zeros; their tag vld=0 hides whatever comes out.
    always_comb begin
        mul_x1 = FP32_ZERO;
        mul_x2 = FP32_ZERO;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                mul_x1 = req_x1[32*i +: 32];
                mul_x2 = req_x2[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else if (mul_en) begin
            r_tag[0].vld <= w_issue;
            r_tag[0].id  <= TAG_ID_W'(w_gid);
            for (int k = 1; k < MUL_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

`ifdef FP32_MUL_ARB_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

    for (genvar g = 0; g < N_REQ; g++) begin : g_issue_cnt
        logic [31:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_issue && w_grant[g] && (r_cnt != 32'hFFFF_FFFF)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign issue_cnt[32*g +: 32] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp32_mul_arbiter.sv
//------------------------------------------------------------------------------
// tb_fp32_mul_arbiter : randomized scoreboard bench with a 4-stage FP32 multiplier model
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fp32_mul_arbiter;

    localparam int N   = 4;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0]  req_x1, req_x2;
    logic [31:0]      rsp_y, mul_x1, mul_x2, mul_y;
    logic             mul_en;
`ifdef FP32_MUL_ARB_PERF_EN
    logic [31:0]      stall_cnt;
    logic [N*32-1:0]  issue_cnt;
`endif

    always #5 clk = ~clk;

    fp32_mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .mul_en    (mul_en),
        .mul_x1    (mul_x1),
        .mul_x2    (mul_x2),
        .mul_y     (mul_y)
`ifdef FP32_MUL_ARB_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .issue_cnt (issue_cnt)
`endif
    );

    // FP32 <-> double conversions for normals, zero and infinity; operands are
    // chosen so that every product is exact.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = (f[30:23] == 8'hFF) ? 11'h7FF : 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        e = b[62:52];
        if (e == 11'd0)   return {b[63], 31'd0};
        if (e == 11'h7FF) return {b[63], 8'hFF, b[51:29]};
        return {b[63], 8'(e - 11'd896), b[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    // External multiplier: four enabled stages, no reset, stale contents at start.
    logic [31:0] mp [LAT];
    initial for (int k = 0; k < LAT; k++) mp[k] = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (mul_en) begin
            mp[0] <= fmul(mul_x1, mul_x2);
            for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
        end
    end
    assign mul_y = mp[LAT-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Scoreboard: expected responses in issue order; age counts enabled edges since acceptance.
    typedef struct {
        int          id;
        logic [31:0] y;
        int          age;
    } exp_t;

    exp_t sb[$];
    int   m_ptr = 0;
    int   m_stalls = 0;
    int   m_issues [N];
    bit   prev_en = 1'b0;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_y;

    always @(negedge clk) begin : mon
        exp_t         h;
        bit           out_v;
        bit           stall;
        int           gid;
        logic [N-1:0] exp_rv;
        logic [N-1:0] exp_rr;
        if (rst) begin
            sb.delete();
            m_ptr      = 0;
            m_stalls   = 0;
            for (int i = 0; i < N; i++) m_issues[i] = 0;
            prev_en    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_en)
                for (int k = 0; k < sb.size(); k++) sb[k].age = sb[k].age + 1;
            out_v  = (sb.size() > 0) && (sb[0].age == LAT);
            stall  = 1'b0;
            exp_rv = '0;
            if (out_v) begin
                h      = sb[0];
                stall  = !rsp_ready[h.id];
                exp_rv = N'(1) << h.id;
            end
            chk(mul_en == !stall, "mul_en", 64'(mul_en), 64'(!stall));
            chk(rsp_valid == exp_rv, "rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (out_v) begin
                chk(rsp_y == h.y, "rsp_y", 64'(rsp_y), 64'(h.y));
                if (prev_stall) chk(rsp_y == prev_y, "rsp_y_stable", 64'(rsp_y), 64'(prev_y));
                if (!stall) void'(sb.pop_front());
            end
            gid = -1;
            if (!stall)
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (gid < 0 && req_valid[j]) gid = j;
                end
            exp_rr = (gid >= 0) ? (N'(1) << gid) : '0;
            chk(req_ready == exp_rr, "req_ready", 64'(req_ready), 64'(exp_rr));
            if (gid >= 0) begin
                sb.push_back('{gid, fmul(req_x1[32*gid +: 32], req_x2[32*gid +: 32]), 0});
                m_ptr = (gid + 1) % N;
                m_issues[gid]++;
            end
            if (stall) m_stalls++;
            prev_en    = mul_en;
            prev_stall = stall;
            prev_y     = rsp_y;
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h3F80_0000;
            1: return 32'h4000_0000;
            2: return 32'h4040_0000;
            3: return 32'h3F00_0000;
            4: return 32'hC000_0000;
            5: return 32'h3FC0_0000;
            6: return 32'h4080_0000;
            7: return 32'hBF40_0000;
            8: return 32'h0000_0000;
            default: return 32'h4120_0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_x1[32*i +: 32] = a;
        req_x2[32*i +: 32] = b;
    endtask

    task automatic idle();
        req_valid = '0;
        rsp_ready = '1;
    endtask

    task automatic drain(input int max_cyc);
        idle();
        for (int k = 0; k < max_cyc && sb.size() > 0; k++) tick();
        chk(sb.size() == 0, "drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk(rsp_valid == '0, "rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk(mul_en == 1'b1, "rst_mul_en", 64'(mul_en), 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic backpressure();
        bit seen;
        req_valid = 4'b1110;
        rsp_ready = 4'b1101;
        for (int i = 0; i < N; i++) set_req(i, pick(), pick());
        repeat (3) tick();
        req_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rsp_valid[1]) seen = 1'b1;
            else tick();
        end
        chk(seen, "bp_rsp1_seen", 64'(seen), 64'd1);
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid = '0;
        rsp_ready = '1;
        drain(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_x1 = '0;
        req_x2 = '0;
        repeat (2) tick();
        chk(rsp_valid == '0, "reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk(req_ready == '0, "reset_req_ready", 64'(req_ready), 64'd0);
        chk(mul_en == 1'b1, "reset_mul_en", 64'(mul_en), 64'd1);
        rst = 1'b0;
        tick();

        // Single request from requester 0.
        set_req(0, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        tick();
        drain(10);

        // Special values from requester 2.
        set_req(2, 32'h7F80_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        tick();
        set_req(2, 32'h0000_0000, 32'h4000_0000);
        tick();
        drain(10);

        // All requesters busy, full throughput.
        set_req(0, 32'h4040_0000, 32'h3F00_0000);
        set_req(1, 32'hC000_0000, 32'h4040_0000);
        req_valid = 4'b1111;
        for (int c = 0; c < 24; c++) begin
            tick();
            for (int i = 0; i < N; i++) set_req(i, pick(), pick());
        end
        drain(10);

        // Reset with three ops in flight and the pointer parked at 3.
        set_req(1, pick(), pick());
        set_req(2, pick(), pick());
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        repeat (2) tick();
        req_valid = '0;
        tick();
        #1 rst = 1'b1;
        #1 chk(rsp_valid == '0, "async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) tick();
        req_valid = 4'b1100;
        tick();
        drain(10);

        // Clean counters, ten issues to requester 0, then backpressure on requester 1.
        pulse_rst();
        set_req(0, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0001;
        repeat (10) tick();
        drain(10);
        backpressure();
`ifdef FP32_MUL_ARB_PERF_EN
        chk(stall_cnt == 32'd3, "stall_cnt", 64'(stall_cnt), 64'd3);
        chk(issue_cnt[31:0] == 32'd10, "issue_cnt0", 64'(issue_cnt[31:0]), 64'd10);
        chk(issue_cnt[63:32] == 32'd1, "issue_cnt1", 64'(issue_cnt[63:32]), 64'd1);
`endif

        // Random traffic and random response backpressure.
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                set_req(i, pick(), pick());
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        drain(40);
`ifdef FP32_MUL_ARB_PERF_EN
        chk(stall_cnt == 32'(m_stalls), "stall_cnt_rand", 64'(stall_cnt), 64'(m_stalls));
        for (int i = 0; i < N; i++)
            chk(issue_cnt[32*i +: 32] == 32'(m_issues[i]), "issue_cnt_rand",
                64'(issue_cnt[32*i +: 32]), 64'(m_issues[i]));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
